predecode_queue: RTL and testbench

Parametrised instruction buffer between fetch and decode. It stores fetched instruction words with their PC in a DEPTH-entry FIFO and predecodes control-flow fields when each word is pushed. On dequeue it drives flags to decode and issue, plus a one-cycle OS-redirect pulse. A HALTED state stops the flow of instructions until a flush arrives.

---
 rtl/predecode_queue.sv | 165 ++++++++++++++++
 tb/tb_predecode_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/predecode_queue.sv
// predecode_queue
//   Instruction buffer between fetch and decode. Words are predecoded on push
//   (branch condition, SWI, halt, reset marker) and stored with their PC in a
//   DEPTH-entry FIFO. The head entry drives decode directly. Popping a SWI, or
//   a halt while in BIOS, pulses an OS redirect. Popping a halt outside BIOS
//   stops the flow of instructions (HALTED) until flush.
//
// Optional feature: define PREDECODE_STATS_EN to add saturating pop and branch
// counters (pop_count, branch_count) that clear on flush.
//
// Ports
//   clock, reset (async active-low), flush, is_bios
//   in_valid/in_ready/in_instruction/in_pc       : push side
//   out_valid/out_ready/out_instruction/out_pc   : pop side (head entry)
//   out_branch_condition, out_is_swi/halt/reset  : head predecode flags
//   redirect_valid/redirect_address              : one-cycle OS redirect
//   count                                        : occupancy
//   pop_count, branch_count                      : stats (PREDECODE_STATS_EN)
module predecode_queue #(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int ADDRESS_WIDTH     = 16,
    parameter int DEPTH             = 4,
    parameter int OS_START          = 2048
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          is_bios,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INSTRUCTION_WIDTH-1:0]  in_instruction,
    input  logic [ADDRESS_WIDTH-1:0]      in_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INSTRUCTION_WIDTH-1:0]  out_instruction,
    output logic [ADDRESS_WIDTH-1:0]      out_pc,
    output logic [4:0]                    out_branch_condition,
    output logic                          out_is_swi,
    output logic                          out_is_halt,
    output logic                          out_is_reset,
    output logic                          redirect_valid,
    output logic [ADDRESS_WIDTH-1:0]      redirect_address,
    output logic [$clog2(DEPTH):0]        count
`ifdef PREDECODE_STATS_EN
    ,
    output logic [15:0]                   pop_count,
    output logic [15:0]                   branch_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] NO_BRANCH = 5'h1f;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] word;
        logic [ADDRESS_WIDTH-1:0]     pc;
        logic [4:0]                   cond;
        logic                         swi;
        logic                         halt;
        logic                         rst;
    } entry_t;

    typedef enum logic {RUN, HALTED} state_t;

    function automatic entry_t predecode(input logic [INSTRUCTION_WIDTH-1:0] w,
                                         input logic [ADDRESS_WIDTH-1:0] pc);
        entry_t e;
        e.word = w;
        e.pc   = pc;
        e.cond = NO_BRANCH;
        e.swi  = 1'b0;
        e.halt = 1'b0;
        e.rst  = (w[15:0] == 16'hffff);
        case (w[15:12])
            4'd13: e.cond = {1'b0, w[11:8]};
            4'd4:  if (w[11:8] == 4'd7) e.cond = {1'b0, w[7:4]};  // BX form
            4'd12: begin
                e.cond = 5'h0e;
                e.swi  = 1'b1;
            end
            4'd14: e.halt = w[11];
            default: ;
        endcase
        return e;
    endfunction

    entry_t         mem [DEPTH];
    entry_t         head;
    logic [AW:0]    wr_ptr, rd_ptr;
    state_t         state;
    logic           full, empty, push, pop;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

    assign in_ready  = !full && (state == RUN);
    assign out_valid = !empty && (state == RUN);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head = mem[rd_ptr[AW-1:0]];

    always_comb begin
        out_instruction      = '0;
        out_pc               = '0;
        out_branch_condition = NO_BRANCH;
        out_is_swi           = 1'b0;
        out_is_halt          = 1'b0;
        out_is_reset         = 1'b0;
        if (!empty) begin
            out_instruction      = head.word;
            out_pc               = head.pc;
            out_branch_condition = head.cond;
            out_is_swi           = head.swi;
            out_is_halt          = head.halt;
            out_is_reset         = head.rst;
        end
    end

    assign redirect_address = redirect_valid ? ADDRESS_WIDTH'(OS_START) : '0;

    // Storage needs no reset: emptiness is tracked by the pointers alone.
    // A push dropped by flush must not land either, hence the !flush term.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= predecode(in_instruction, in_pc);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            state          <= RUN;
            redirect_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            state          <= RUN;
            redirect_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            redirect_valid <= pop && (head.swi || (head.halt && is_bios));
            if (pop && head.halt && !is_bios) state <= HALTED;
        end
    end

`ifdef PREDECODE_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pop_count    <= '0;
            branch_count <= '0;
        end else if (flush) begin
            pop_count    <= '0;
            branch_count <= '0;
        end else if (pop) begin
            if (pop_count != 16'hffff) pop_count <= pop_count + 16'd1;
            if (head.cond != NO_BRANCH && branch_count != 16'hffff)
                branch_count <= branch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_predecode_queue.sv
// Directed bench for predecode_queue (DEPTH=4, OS_START=2048).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_predecode_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        is_bios = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instruction = '0;
    logic [15:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instruction;
    logic [15:0] out_pc;
    logic [4:0]  out_branch_condition;
    logic        out_is_swi, out_is_halt, out_is_reset;
    logic        redirect_valid;
    logic [15:0] redirect_address;
    logic [2:0]  count;
`ifdef PREDECODE_STATS_EN
    logic [15:0] pop_count, branch_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    predecode_queue #(
        .INSTRUCTION_WIDTH(16), .ADDRESS_WIDTH(16), .DEPTH(4), .OS_START(2048)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush), .is_bios(is_bios),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc(out_pc),
        .out_branch_condition(out_branch_condition),
        .out_is_swi(out_is_swi), .out_is_halt(out_is_halt), .out_is_reset(out_is_reset),
        .redirect_valid(redirect_valid), .redirect_address(redirect_address),
        .count(count)
`ifdef PREDECODE_STATS_EN
        , .pop_count(pop_count), .branch_count(branch_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic push1(input logic [15:0] w, input logic [15:0] pc);
        in_valid = 1'b1; in_instruction = w; in_pc = pc;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state, before any clock edge.
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cond", out_branch_condition, 5'h1f);
        chk("rst_count", count, 0);
        chk("rst_redirect", redirect_valid, 0);
        chk("rst_redir_addr", redirect_address, 0);
        chk("rst_flags", {out_is_swi, out_is_halt, out_is_reset}, 0);
        chk("rst_instr", out_instruction, 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // First push: branch with condition 3.
        push1(16'hd305, 16'd10);
        chk("p1_valid", out_valid, 1);
        chk("p1_cond", out_branch_condition, 5'h03);
        chk("p1_pc", out_pc, 10);
        chk("p1_count", count, 1);
        chk("p1_instr", out_instruction, 16'hd305);
        pop1();
        chk("p1_pop_count", count, 0);
        chk("p1_pop_valid", out_valid, 0);

        // Fill to full, then push and pop together across the pointer wrap.
        for (int i = 0; i < 4; i++) push1(16'h1000 + 16'(i), 16'd100 + 16'(i));
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_instruction = 16'h2000 + 16'((i == 0) ? 0 : i - 1);
            chk($sformatf("wrap_head%0d", i), out_instruction,
                (i < 4) ? 32'h1000 + i : 32'h2000 + (i - 4));
            cyc();
            chk($sformatf("wrap_count%0d", i), count, 3);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drain_head%0d", i), out_instruction, 32'h2004 + i);
            cyc();
        end
        out_ready = 1'b0;
        chk("drain_count", count, 0);

        // SWI pop redirects for exactly one cycle.
        push1(16'hc000, 16'd20);
        chk("swi_flag", out_is_swi, 1);
        chk("swi_cond", out_branch_condition, 5'h0e);
        pop1();
        chk("swi_redir", redirect_valid, 1);
        chk("swi_addr", redirect_address, 2048);
        cyc();
        chk("swi_redir_end", redirect_valid, 0);
        chk("swi_addr_end", redirect_address, 0);

        // Halt in BIOS: redirect, stay in RUN.
        push1(16'he800, 16'd21);
        chk("bh_flag", out_is_halt, 1);
        is_bios = 1'b1;
        pop1();
        is_bios = 1'b0;
        chk("bh_redir", redirect_valid, 1);
        chk("bh_in_ready", in_ready, 1);
        cyc();
        chk("bh_redir_end", redirect_valid, 0);

        // Halt outside BIOS: stop, hold remaining entries, flush recovers.
        push1(16'he800, 16'd30);
        push1(16'h0001, 16'd31);
        push1(16'h0002, 16'd32);
        pop1();
        chk("h_out_valid", out_valid, 0);
        chk("h_in_ready", in_ready, 0);
        chk("h_count", count, 2);
        chk("h_head", out_instruction, 16'h0001);
        chk("h_redir", redirect_valid, 0);
        push1(16'h0003, 16'd33);
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        chk("h_held_count", count, 2);
        flush = 1'b1; cyc(); flush = 1'b0;
        chk("fl_count", count, 0);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_out_valid", out_valid, 0);

        // BX and the reset marker.
        push1(16'h4770, 16'd40);
        push1(16'hffff, 16'd41);
        push1(16'h4600, 16'd42);
        chk("bx_cond", out_branch_condition, 5'h07);
        chk("bx_reset", out_is_reset, 0);
        pop1();
        chk("ff_cond", out_branch_condition, 5'h1f);
        chk("ff_reset", out_is_reset, 1);
        chk("ff_pc", out_pc, 41);
        pop1();
        chk("op4_cond", out_branch_condition, 5'h1f);
        pop1();

        // Flush beats a same-cycle push.
        in_valid = 1'b1; in_instruction = 16'hd100; flush = 1'b1;
        cyc();
        in_valid = 1'b0; flush = 1'b0;
        chk("fp_count", count, 0);
        chk("fp_out_valid", out_valid, 0);
        cyc();
        chk("fp_count_later", count, 0);

        // Async reset mid-operation clears without a clock edge.
        push1(16'h0005, 16'd50);
        #2 reset = 1'b0;
        #1;
        chk("ar_count", count, 0);
        chk("ar_out_valid", out_valid, 0);
        #1 reset = 1'b1;

`ifdef PREDECODE_STATS_EN
        cyc();
        flush = 1'b1; cyc(); flush = 1'b0;
        push1(16'hd100, 16'd60);
        push1(16'h0001, 16'd61);
        push1(16'h0002, 16'd62);
        for (int i = 0; i < 3; i++) pop1();
        chk("st_pop", pop_count, 3);
        chk("st_branch", branch_count, 1);
        flush = 1'b1; cyc(); flush = 1'b0;
        chk("st_pop_fl", pop_count, 0);
        chk("st_branch_fl", branch_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
